// File: rtl/mem_arb_pkg.sv
// Shared helpers for the round-robin memory read arbiter.
package mem_arb_pkg;

    // Index width that never collapses to zero bits for tiny counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of source IDs for accepted reads; its fill level is the
// number of reads in flight.
module mem_arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [W-1:0]     i_din,
    input  logic             i_pop,
    output logic [W-1:0]     o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int IDX_W = clog2_min1(DEPTH);

    logic [CNT_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_rd_ptr;
    logic [W-1:0]     r_mem [DEPTH];
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit, so the difference is the fill level.
    assign w_wr_idx  = IDX_W'(r_wr_ptr & CNT_W'(DEPTH - 1));
    assign w_rd_idx  = IDX_W'(r_rd_ptr & CNT_W'(DEPTH - 1));
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_full    = (o_count == CNT_W'(DEPTH));
    assign o_empty   = (o_count == '0);
    assign o_dout    = r_mem[w_rd_idx];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[w_wr_idx] <= i_din;
    end

endmodule

// File: rtl/mem_rr_arb.sv
// Round-robin arbiter sharing one memory read port among NUM_SRC requesters,
// with in-order response routing through a source-ID FIFO.
module mem_rr_arb
    import mem_arb_pkg::*;
#(
    parameter  int NUM_SRC         = 4,
    parameter  int ADDR_W          = 32,
    parameter  int DATA_W          = 64,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_rd_req_val,
    input  logic [NUM_SRC*ADDR_W-1:0] src_rd_req_addr,
    output logic [NUM_SRC-1:0]        src_rd_req_rdy,
    output logic [NUM_SRC-1:0]        src_rd_resp_val,
    output logic [DATA_W-1:0]         src_rd_resp_data,
    input  logic [NUM_SRC-1:0]        src_rd_resp_rdy,
    output logic                      dst_rd_req_val,
    output logic [ADDR_W-1:0]         dst_rd_req_addr,
    input  logic                      dst_rd_req_rdy,
    input  logic                      dst_rd_resp_val,
    input  logic [DATA_W-1:0]         dst_rd_resp_data,
    output logic                      dst_rd_resp_rdy,
    output logic [CNT_W-1:0]          outstanding_cnt,
    output logic                      err_unexp_resp
);

    localparam int SRC_ID_W = clog2_min1(NUM_SRC);

    logic [SRC_ID_W-1:0] r_rr_ptr;
    logic                r_lock;
    logic [SRC_ID_W-1:0] r_lock_id;
    logic                r_err;

    logic [SRC_ID_W-1:0] w_grant_srch;
    logic                w_found;
    logic [SRC_ID_W-1:0] w_grant;
    logic [SRC_ID_W-1:0] w_rr_next;
    logic [SRC_ID_W-1:0] w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_req_ok;
    logic                w_push;
    logic                w_pop;

    always_comb begin
        w_grant_srch = r_rr_ptr;
        w_found      = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!w_found && src_rd_req_val[(int'(r_rr_ptr) + k) % NUM_SRC]) begin
                w_grant_srch = SRC_ID_W'((int'(r_rr_ptr) + k) % NUM_SRC);
                w_found      = 1'b1;
            end
        end
    end

    // A stalled request keeps its grant so address and ID stay stable until accepted.
    assign w_grant   = r_lock ? r_lock_id : w_grant_srch;
    assign w_rr_next = (w_grant == SRC_ID_W'(NUM_SRC - 1)) ? '0 : w_grant + 1'b1;

    // Full uses the registered count only: no combinational resp->req path.
    assign w_req_ok        = ~rst & ~w_full;
    assign dst_rd_req_val  = (|src_rd_req_val) & w_req_ok;
    assign dst_rd_req_addr = src_rd_req_addr[w_grant*ADDR_W +: ADDR_W];
    assign w_push          = dst_rd_req_val & dst_rd_req_rdy;

    always_comb begin
        src_rd_req_rdy          = '0;
        src_rd_req_rdy[w_grant] = dst_rd_req_rdy & w_req_ok;
    end

    always_comb begin
        src_rd_resp_val = '0;
        if (!w_empty) src_rd_resp_val[w_head] = dst_rd_resp_val;
    end

    assign dst_rd_resp_rdy  = ~w_empty & src_rd_resp_rdy[w_head];
    assign src_rd_resp_data = dst_rd_resp_data;
    assign w_pop            = dst_rd_resp_val & dst_rd_resp_rdy;
    assign err_unexp_resp   = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_push) begin
                r_rr_ptr <= w_rr_next;
                r_lock   <= 1'b0;
            end else if (dst_rd_req_val) begin
                r_lock    <= 1'b1;
                r_lock_id <= w_grant;
            end
            if (dst_rd_resp_val && w_empty) r_err <= 1'b1;
        end
    end

    mem_arb_id_fifo #(
        .W     (SRC_ID_W),
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_grant),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (outstanding_cnt)
    );

endmodule

// File: tb/tb_mem_rr_arb.sv
// Scoreboard bench for mem_rr_arb: bench-modelled sources and memory, per-scenario checks.
module tb_mem_rr_arb;

    localparam int NUM_SRC = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int MAX_OUT = 4;
    localparam int CNT_W   = 3;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_SRC-1:0]        src_rd_req_val;
    logic [NUM_SRC*ADDR_W-1:0] src_rd_req_addr;
    logic [NUM_SRC-1:0]        src_rd_req_rdy;
    logic [NUM_SRC-1:0]        src_rd_resp_val;
    logic [DATA_W-1:0]         src_rd_resp_data;
    logic [NUM_SRC-1:0]        src_rd_resp_rdy;
    logic                      dst_rd_req_val;
    logic [ADDR_W-1:0]         dst_rd_req_addr;
    logic                      dst_rd_req_rdy;
    logic                      dst_rd_resp_val;
    logic [DATA_W-1:0]         dst_rd_resp_data;
    logic                      dst_rd_resp_rdy;
    logic [CNT_W-1:0]          outstanding_cnt;
    logic                      err_unexp_resp;

    mem_rr_arb #(
        .NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst),
        .src_rd_req_val(src_rd_req_val), .src_rd_req_addr(src_rd_req_addr),
        .src_rd_req_rdy(src_rd_req_rdy), .src_rd_resp_val(src_rd_resp_val),
        .src_rd_resp_data(src_rd_resp_data), .src_rd_resp_rdy(src_rd_resp_rdy),
        .dst_rd_req_val(dst_rd_req_val), .dst_rd_req_addr(dst_rd_req_addr),
        .dst_rd_req_rdy(dst_rd_req_rdy), .dst_rd_resp_val(dst_rd_resp_val),
        .dst_rd_resp_data(dst_rd_resp_data), .dst_rd_resp_rdy(dst_rd_resp_rdy),
        .outstanding_cnt(outstanding_cnt), .err_unexp_resp(err_unexp_resp)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat     = 0;
    logic mem_en, stray, req_rdy_cfg;
    logic [NUM_SRC-1:0] resp_rdy_cfg;

    logic [ADDR_W-1:0] src_list [NUM_SRC][8];
    int                src_len  [NUM_SRC];
    int                src_pos  [NUM_SRC];

    logic [ADDR_W-1:0] mem_addr_q[$];
    int                mem_due_q[$];
    int                sb_src_q[$];
    logic [DATA_W-1:0] sb_data_q[$];

    int                 grant_log[$];
    logic               log_req_val[$];
    logic [ADDR_W-1:0]  log_addr[$];
    logic [CNT_W-1:0]   log_cnt[$];
    logic               log_resp_rdy[$];
    logic [NUM_SRC-1:0] log_resp_val[$];
    logic               log_hs[$];
    logic               log_err[$];
    logic [NUM_SRC-1:0] resp_hs_vec[$];

    function automatic logic [DATA_W-1:0] mk_data(input logic [ADDR_W-1:0] a);
        return {~a, a};
    endfunction

    function automatic bit pending_src();
        for (int i = 0; i < NUM_SRC; i++) if (src_pos[i] < src_len[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_bench();
        for (int i = 0; i < NUM_SRC; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        mem_addr_q.delete(); mem_due_q.delete();
        sb_src_q.delete();   sb_data_q.delete();
        grant_log.delete();  log_req_val.delete(); log_addr.delete();
        log_cnt.delete();    log_resp_rdy.delete(); log_resp_val.delete();
        log_hs.delete();     log_err.delete();     resp_hs_vec.delete();
    endtask

    // One cycle: drive inputs, observe at negedge, advance to posedge+1.
    task automatic tick();
        logic [NUM_SRC-1:0] w;
        logic [NUM_SRC-1:0] exp_v;
        logic [ADDR_W-1:0]  a;
        int                 g;
        bit                 from_mem;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_pos[i] < src_len[i]) begin
                src_rd_req_val[i] = 1'b1;
                src_rd_req_addr[i*ADDR_W +: ADDR_W] = src_list[i][src_pos[i]];
            end else begin
                src_rd_req_val[i] = 1'b0;
                src_rd_req_addr[i*ADDR_W +: ADDR_W] = '0;
            end
        end
        dst_rd_req_rdy  = req_rdy_cfg;
        src_rd_resp_rdy = resp_rdy_cfg;
        from_mem = 1'b0;
        if (mem_en && mem_due_q.size() != 0 && mem_due_q[0] <= cyc) begin
            dst_rd_resp_val  = 1'b1;
            dst_rd_resp_data = mk_data(mem_addr_q[0]);
            from_mem = 1'b1;
        end else if (stray) begin
            dst_rd_resp_val  = 1'b1;
            dst_rd_resp_data = 64'hDEAD_BEEF_0BAD_F00D;
        end else begin
            dst_rd_resp_val  = 1'b0;
            dst_rd_resp_data = '0;
        end

        @(negedge clk);
        log_req_val.push_back(dst_rd_req_val);
        log_addr.push_back(dst_rd_req_addr);
        log_cnt.push_back(outstanding_cnt);
        log_resp_rdy.push_back(dst_rd_resp_rdy);
        log_resp_val.push_back(src_rd_resp_val);
        log_hs.push_back(dst_rd_req_val && dst_rd_req_rdy);
        log_err.push_back(err_unexp_resp);

        if (dst_rd_req_val && dst_rd_req_rdy) begin
            w = src_rd_req_rdy & src_rd_req_val;
            n_tests++;
            if (!$onehot(w)) begin
                n_fail++;
                $display("FAIL req_ack cyc=%0d: rdy&val=%b, required exactly one bit", cyc, w);
            end else begin
                g = 0;
                for (int i = 0; i < NUM_SRC; i++) if (w[i]) g = i;
                a = src_list[g][src_pos[g]];
                n_tests++;
                if (dst_rd_req_addr !== a) begin
                    n_fail++;
                    $display("FAIL req_addr cyc=%0d src=%0d: got %h, required %h", cyc, g, dst_rd_req_addr, a);
                end
                grant_log.push_back(g);
                mem_addr_q.push_back(a);
                mem_due_q.push_back(cyc + 1 + lat);
                sb_src_q.push_back(g);
                sb_data_q.push_back(mk_data(a));
                src_pos[g]++;
            end
        end

        if (dst_rd_resp_val && dst_rd_resp_rdy) begin
            resp_hs_vec.push_back(src_rd_resp_val);
            n_tests++;
            if (sb_src_q.size() == 0) begin
                n_fail++;
                $display("FAIL resp_unexpected cyc=%0d: response accepted, required none pending", cyc);
            end else begin
                exp_v = '0;
                exp_v[sb_src_q[0]] = 1'b1;
                if (src_rd_resp_val !== exp_v || src_rd_resp_data !== sb_data_q[0]) begin
                    n_fail++;
                    $display("FAIL resp_route cyc=%0d: val=%b data=%h, required val=%b data=%h",
                             cyc, src_rd_resp_val, src_rd_resp_data, exp_v, sb_data_q[0]);
                end
                void'(sb_src_q.pop_front());
                void'(sb_data_q.pop_front());
            end
            if (from_mem) begin
                void'(mem_addr_q.pop_front());
                void'(mem_due_q.pop_front());
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        mem_en       = 1'b1;
        req_rdy_cfg  = 1'b1;
        resp_rdy_cfg = '1;
        while ((sb_src_q.size() != 0 || pending_src()) && n < max_cyc) begin
            tick();
            n++;
        end
        n_tests++;
        if (n >= max_cyc) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d responses pending, required 0", sb_src_q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_rd_req_val   = '0;
        src_rd_req_addr  = '0;
        dst_rd_req_rdy   = 1'b0;
        dst_rd_resp_val  = 1'b0;
        dst_rd_resp_data = '0;
        src_rd_resp_rdy  = '0;
        clear_bench();
        mem_en = 1'b1; stray = 1'b0; req_rdy_cfg = 1'b1; resp_rdy_cfg = '1; lat = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        src_rd_req_val   = '1;
        src_rd_req_addr  = {32'h400, 32'h300, 32'h200, 32'h100};
        dst_rd_req_rdy   = 1'b1;
        dst_rd_resp_val  = 1'b1;
        dst_rd_resp_data = '1;
        src_rd_resp_rdy  = '1;
        @(negedge clk);
        n_tests++; if (dst_rd_req_val !== 1'b0) begin n_fail++; $display("FAIL rst_req_val: got %b, required 0", dst_rd_req_val); end
        n_tests++; if (src_rd_req_rdy !== '0) begin n_fail++; $display("FAIL rst_req_rdy: got %b, required 0000", src_rd_req_rdy); end
        n_tests++; if (src_rd_resp_val !== '0) begin n_fail++; $display("FAIL rst_resp_val: got %b, required 0000", src_rd_resp_val); end
        n_tests++; if (dst_rd_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_resp_rdy: got %b, required 0", dst_rd_resp_rdy); end
        n_tests++; if (outstanding_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d, required 0", outstanding_cnt); end
        n_tests++; if (err_unexp_resp !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b, required 0", err_unexp_resp); end
        @(posedge clk);
        #1;
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        lat = 1;
        src_list[0][0] = 32'h100; src_len[0] = 1;
        src_list[2][0] = 32'h200; src_len[2] = 1;
        for (int t = 0; t < 6; t++) tick();
        n_tests++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 2) begin
            n_fail++; $display("FAIL basic_grant: got %0d grants first=%0d, required order 0,2", grant_log.size(), grant_log[0]);
        end
        n_tests++;
        if ({log_cnt[1], log_cnt[2], log_cnt[3], log_cnt[4]} !== {3'd1, 3'd2, 3'd1, 3'd0}) begin
            n_fail++; $display("FAIL basic_cnt: got %0d,%0d,%0d,%0d, required 1,2,1,0", log_cnt[1], log_cnt[2], log_cnt[3], log_cnt[4]);
        end
        n_tests++;
        if (resp_hs_vec.size() != 2 || resp_hs_vec[0] !== 4'b0001 || resp_hs_vec[1] !== 4'b0100) begin
            n_fail++; $display("FAIL basic_resp_order: got %0d responses first=%b, required 0001 then 0100", resp_hs_vec.size(), resp_hs_vec[0]);
        end
    endtask

    task automatic test_rr_fairness();
        do_reset();
        lat = 3;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 0; k < 3; k++) src_list[i][k] = 32'h1000 * (i + 1) + 32'(k * 4);
            src_len[i] = 3;
        end
        for (int t = 0; t < 6; t++) tick();
        drain(80);
        n_tests++;
        if (log_cnt[4] !== 3'd4 || log_req_val[4] !== 1'b0) begin
            n_fail++; $display("FAIL rr_full_stall: cnt=%0d req_val=%b, required cnt=4 req_val=0", log_cnt[4], log_req_val[4]);
        end
        n_tests++;
        if (log_hs[5] !== 1'b1 || log_cnt[5] !== 3'd3) begin
            n_fail++; $display("FAIL rr_resume: hs=%b cnt=%0d, required hs=1 cnt=3", log_hs[5], log_cnt[5]);
        end
        n_tests++;
        if (grant_log.size() != 12) begin
            n_fail++; $display("FAIL rr_count: got %0d grants, required 12", grant_log.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                n_tests++;
                if (grant_log[k] != k % NUM_SRC) begin
                    n_fail++; $display("FAIL rr_order[%0d]: got %0d, required %0d", k, grant_log[k], k % NUM_SRC);
                end
            end
        end
    endtask

    task automatic test_lock();
        do_reset();
        req_rdy_cfg = 1'b0;
        src_list[1][0] = 32'h1100; src_len[1] = 1;
        tick();
        src_list[0][0] = 32'h0AA0; src_len[0] = 1;
        tick();
        tick();
        req_rdy_cfg = 1'b1;
        tick();
        tick();
        drain(20);
        for (int t = 0; t < 3; t++) begin
            n_tests++;
            if (log_req_val[t] !== 1'b1 || log_addr[t] !== 32'h1100) begin
                n_fail++; $display("FAIL lock_addr[%0d]: val=%b addr=%h, required val=1 addr=00001100", t, log_req_val[t], log_addr[t]);
            end
        end
        n_tests++;
        if (log_hs[3] !== 1'b1 || grant_log.size() != 2 || grant_log[0] != 1 || grant_log[1] != 0) begin
            n_fail++; $display("FAIL lock_grant: hs=%b grants=%0d first=%0d, required src1 on rdy cycle then src0", log_hs[3], grant_log.size(), grant_log[0]);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        lat    = 0;
        mem_en = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_list[i][0] = 32'h5000 + 32'(i * 16);
            src_len[i] = 1;
        end
        src_list[0][1] = 32'h5800; src_len[0] = 2;
        for (int t = 0; t < 4; t++) tick();
        mem_en = 1'b1;
        tick();
        mem_en = 1'b0;
        tick();
        tick();
        drain(30);
        n_tests++;
        if (log_cnt[4] !== 3'd4 || log_req_val[4] !== 1'b0 || log_resp_rdy[4] !== 1'b1) begin
            n_fail++; $display("FAIL full_pop_cycle: cnt=%0d req_val=%b resp_rdy=%b, required 4,0,1", log_cnt[4], log_req_val[4], log_resp_rdy[4]);
        end
        n_tests++;
        if (log_cnt[5] !== 3'd3 || log_hs[5] !== 1'b1 || log_cnt[6] !== 3'd4) begin
            n_fail++; $display("FAIL full_pop_refill: cnt=%0d hs=%b next cnt=%0d, required 3,1,4", log_cnt[5], log_hs[5], log_cnt[6]);
        end
    endtask

    task automatic test_resp_backpressure();
        do_reset();
        lat = 0;
        resp_rdy_cfg = 4'b1011;
        src_list[2][0] = 32'h2220; src_len[2] = 1;
        for (int t = 0; t < 3; t++) tick();
        resp_rdy_cfg = '1;
        tick();
        tick();
        for (int t = 1; t < 3; t++) begin
            n_tests++;
            if (log_resp_rdy[t] !== 1'b0 || log_resp_val[t] !== 4'b0100 || log_cnt[t] !== 3'd1) begin
                n_fail++; $display("FAIL bp_hold[%0d]: resp_rdy=%b val=%b cnt=%0d, required 0,0100,1", t, log_resp_rdy[t], log_resp_val[t], log_cnt[t]);
            end
        end
        n_tests++;
        if (log_resp_rdy[3] !== 1'b1 || log_cnt[4] !== 3'd0 || sb_src_q.size() != 0) begin
            n_fail++; $display("FAIL bp_release: resp_rdy=%b cnt=%0d pending=%0d, required 1,0,0", log_resp_rdy[3], log_cnt[4], sb_src_q.size());
        end
    endtask

    task automatic test_err_reset();
        do_reset();
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        tick();
        n_tests++;
        if (log_resp_rdy[0] !== 1'b0 || log_resp_val[0] !== '0) begin
            n_fail++; $display("FAIL err_stray_route: resp_rdy=%b val=%b, required 0,0000", log_resp_rdy[0], log_resp_val[0]);
        end
        n_tests++;
        if (log_err[0] !== 1'b0 || log_err[1] !== 1'b1 || log_err[2] !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: got %b%b%b, required 011", log_err[0], log_err[1], log_err[2]);
        end
        mem_en = 1'b0;
        src_list[0][0] = 32'h7000; src_len[0] = 1;
        src_list[1][0] = 32'h7100; src_len[1] = 1;
        tick();
        tick();
        tick();
        n_tests++;
        if (log_cnt[5] !== 3'd2 || log_err[5] !== 1'b1) begin
            n_fail++; $display("FAIL err_burst: cnt=%0d err=%b, required 2,1", log_cnt[5], log_err[5]);
        end
        rst = 1'b1;
        dst_rd_resp_val  = 1'b1;
        dst_rd_resp_data = '1;
        @(negedge clk);
        n_tests++;
        if (outstanding_cnt !== 3'd0 || err_unexp_resp !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_state: cnt=%0d err=%b, required 0,0", outstanding_cnt, err_unexp_resp);
        end
        n_tests++;
        if (dst_rd_resp_rdy !== 1'b0 || src_rd_resp_val !== '0 || dst_rd_req_val !== 1'b0 || src_rd_req_rdy !== '0) begin
            n_fail++; $display("FAIL mid_rst_outputs: resp_rdy=%b resp_val=%b req_val=%b req_rdy=%b, required all 0",
                               dst_rd_resp_rdy, src_rd_resp_val, dst_rd_req_val, src_rd_req_rdy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_bench();
        mem_en = 1'b1;
        stray  = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        tick();
        n_tests++;
        if (log_resp_rdy[0] !== 1'b0 || log_resp_val[0] !== '0) begin
            n_fail++; $display("FAIL post_rst_stray: resp_rdy=%b val=%b, required 0,0000", log_resp_rdy[0], log_resp_val[0]);
        end
        n_tests++;
        if (log_cnt[1] !== 3'd0 || log_err[0] !== 1'b0 || log_err[1] !== 1'b1) begin
            n_fail++; $display("FAIL post_rst_err: cnt=%0d err=%b%b, required 0,01", log_cnt[1], log_err[0], log_err[1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rr_fairness();
        test_lock();
        test_full_pop();
        test_resp_backpressure();
        test_err_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_rr_arb.md
Name: mem_rr_arb

Overview:
Round-robin read arbiter that shares one memory read port among NUM_SRC requesters and keeps up to MAX_OUTSTANDING reads in flight. Requests are forwarded combinationally to the memory. Responses come back in request order and are routed by an in-order source-ID FIFO. It sits between the TCP slow-path engines (state/buffer readers) and a single memory or BRAM controller read port, and replaces strictly-prioritised one-at-a-time muxing.

Parameters:
NUM_SRC, 4, number of requesters (>=2)
ADDR_W, 32, read address width
DATA_W, 64, read data width
MAX_OUTSTANDING, 4, max accepted-but-unanswered reads; power of 2, >=1
(localparam SRC_ID_W = max(1, clog2(NUM_SRC)); CNT_W = clog2(MAX_OUTSTANDING+1))

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
src_rd_req_val  in  NUM_SRC  per-source request valid
src_rd_req_addr  in  NUM_SRC*ADDR_W  per-source address; source i uses bits [i*ADDR_W +: ADDR_W]
src_rd_req_rdy  out  NUM_SRC  per-source request ready
src_rd_resp_val  out  NUM_SRC  per-source response valid
src_rd_resp_data  out  DATA_W  response data, broadcast to all sources
src_rd_resp_rdy  in  NUM_SRC  per-source response ready
dst_rd_req_val  out  1  request valid to memory
dst_rd_req_addr  out  ADDR_W  request address to memory
dst_rd_req_rdy  in  1  memory request ready
dst_rd_resp_val  in  1  memory response valid
dst_rd_resp_data  in  DATA_W  memory response data
dst_rd_resp_rdy  out  1  response ready to memory
outstanding_cnt  out  CNT_W  reads currently in flight
err_unexp_resp  out  1  sticky flag: dst_rd_resp_val seen while nothing is outstanding

Behaviour:
- Reset (async assert, sync deassert): rr_ptr=0, lock=0, FIFO empty, outstanding_cnt=0, err_unexp_resp=0. All val/rdy outputs are 0 while rst is high. dst_rd_req_addr and src_rd_resp_data are don't-care.
- Grant selection:
  - If lock=1, grant = lock_id.
  - Otherwise grant = the first i with src_rd_req_val[i]=1, searching from rr_ptr upward mod NUM_SRC.
- Request path has 0-cycle latency:
  - dst_rd_req_val = any_val & ~full, where full = (outstanding_cnt == MAX_OUTSTANDING).
  - dst_rd_req_addr = address of the granted source.
  - src_rd_req_rdy[grant] = dst_rd_req_rdy & ~full; all other rdy bits are 0.
- full is computed from the registered count only. A pop in the same cycle does not free a slot for a push (no resp->req combinational path).
- Request handshake (dst_rd_req_val & dst_rd_req_rdy): push grant into the ID FIFO, set rr_ptr = (grant+1) mod NUM_SRC, clear lock.
- Valid stability: if dst_rd_req_val=1 and dst_rd_req_rdy=0, set lock=1 and lock_id=grant. Address and grant then stay stable until the handshake even if another source raises val. Sources must hold val and address until accepted.
- Response routing (FIFO not empty, head = FIFO head ID):
  - src_rd_resp_val[head] = dst_rd_resp_val; other val bits are 0.
  - dst_rd_resp_rdy = src_rd_resp_rdy[head].
  - Pop on dst_rd_resp_val & dst_rd_resp_rdy.
- FIFO empty: dst_rd_resp_rdy=0 and all src_rd_resp_val=0. If dst_rd_resp_val=1, set err_unexp_resp; it clears only on rst.
- outstanding_cnt: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. It never exceeds MAX_OUTSTANDING and never underflows.
- Back-to-back: one request and one response can complete per cycle. Sustained throughput is 1 read/cycle when MAX_OUTSTANDING covers memory latency.
- Reset mid-operation: in-flight IDs are discarded. Responses arriving after reset are not accepted and set err_unexp_resp. The memory must be reset on the same rst.

Decomposition:
- Package mem_arb_pkg: function clog2_min1. Keep SRC_ID_W/CNT_W derivations here only if another block needs them; otherwise they stay localparams.
- Sub-module mem_arb_id_fifo: a sync FIFO of SRC_ID_W x MAX_OUTSTANDING.
  - Pointers with an extra wrap bit; full/empty outputs; registered storage; async reset of pointers only.
  - It also supplies outstanding_cnt.
- The arbiter body holds rr_ptr, lock, the grant search, muxes and the error flag.

Test Plan:
- rst, then src 0 and 2 raise val (addr 0x100, 0x200), dst rdy=1, memory latency 1 → grants 0 then 2 on consecutive cycles; responses D0 go to src0 and D2 to src2; outstanding_cnt 1,2,1,0.
- All 4 sources hold val continuously, rdy=1, MAX_OUTSTANDING=4, memory latency 3 → grant order 0,1,2,3,0,...; no source is granted twice before the others; the 5th request stalls with cnt=4 until the first pop.
- Src1 val, dst_rd_req_rdy=0 for 3 cycles, src0 raises val in cycle 2 → dst_rd_req_addr stays src1's for all 3 cycles; src1 is accepted on the rdy cycle; src0 is granted next.
- Full, with pop and push request in the same cycle → no push that cycle; push next cycle; cnt goes 4→3→4.
- src_rd_resp_rdy[head]=0 for 2 cycles with dst_rd_resp_val=1 → dst_rd_resp_rdy=0 and no pop; the response is delivered when rdy rises.
- dst_rd_resp_val=1 with empty FIFO, then rst asserted mid-burst with 2 outstanding → err_unexp_resp=1 and stays set until rst; after rst, cnt=0, all outputs 0, and a stray response is not accepted.
